// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Sequential stimulus-and-capture stage for a three-input combinational
// function. A start request walks {C,B,A} through indices 0..7, holds each
// index for SETTLE cycles and samples the function output on the last edge of
// each window into a shadow register. The shadow is published to the
// registered truth table together with a one-cycle done pulse.
//
// Parameters
//   SETTLE : cycles each input combination is held before sampling (1..15)
//   EXPECT : reference truth table, used only when the compare option is on
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   scan request, sampled on clk (ignored while scanning)
//   A, B, C   out  function inputs, index bits 0, 1, 2 (registered)
//   fout      in   function output, combinational from A/B/C
//   busy      out  high while a scan is in progress
//   done      out  one-cycle pulse, tbl freshly valid
//   tbl       out  captured truth table, bit i = fout for index i.
//                  Named tbl because "table" is a reserved word in
//                  SystemVerilog.
//   match     out  (option) tbl == EXPECT
//   first_err out  (option) lowest index where tbl and EXPECT differ, 0 on match
//
// Build option
//   TRUTH_TABLE_SCANNER_COMPARE_EN : when defined, adds the match/first_err
//   ports and the compare logic. When undefined they are absent and all other
//   behaviour is identical.
// -----------------------------------------------------------------------------
module truth_table_scanner #(
  parameter int         SETTLE = 1,
  parameter logic [7:0] EXPECT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       fout,
  output logic       busy,
  output logic       done,
  output logic [7:0] tbl
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  ,
  output logic       match,
  output logic [2:0] first_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter reload: the window of one index is SETTLE cycles, counted
  // SETTLE-1 down to 0, with the sample taken on the edge where it is 0.
  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  // Parameter sanity check at elaboration.
  generate
    if ((SETTLE < 1) || (SETTLE > 15) || ($bits(EXPECT) != 8)) begin : g_bad_param
      $error("truth_table_scanner: SETTLE must be in 1..15");
    end
  endgenerate

  state_t     state_r, state_s;
  logic [2:0] idx_r, idx_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] shadow_r, shadow_s;
  logic [7:0] tbl_r, tbl_s;
  logic [2:0] abc_r, abc_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       last_s;

`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  logic       match_r, match_s;
  logic [2:0] ferr_r, ferr_s;

  // Lowest bit index where the two words differ; 0 when they are equal.
  function automatic logic [2:0] first_mismatch(input logic [7:0] a,
                                                input logic [7:0] b);
    logic [7:0] d;
    logic [2:0] r;
    d = a ^ b;
    r = 3'd0;
    // Scan downwards so the lowest differing index is written last.
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) begin
        r = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction
`endif

  // Last cycle of the current index window.
  assign last_s = (cnt_r == 4'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (last_s && (idx_r == 3'd7)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        // A start seen during DONE launches the next scan back-to-back.
        if (start) begin
          state_s = ST_SCAN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the datapath and of every registered output. The values
  // computed here are what the outputs show in the cycle after the edge.
  always_comb begin
    idx_s    = idx_r;
    cnt_s    = cnt_r;
    shadow_s = shadow_r;
    tbl_s    = tbl_r;
    abc_s    = 3'd0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    match_s  = match_r;
    ferr_s   = ferr_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Launch: index 0 is driven from the next cycle onwards.
          idx_s    = 3'd0;
          cnt_s    = RELOAD;
          shadow_s = 8'h00;
          busy_s   = 1'b1;
        end else begin
          idx_s    = 3'd0;
        end
      end
      ST_SCAN: begin
        busy_s = 1'b1;
        abc_s  = idx_r;
        if (last_s) begin
          shadow_s[idx_r] = fout;
          if (idx_r == 3'd7) begin
            // Final sample: publish the full table on the same edge, so it
            // appears together with done and A/B/C back at 0.
            busy_s = 1'b0;
            abc_s  = 3'd0;
            done_s = 1'b1;
            tbl_s  = shadow_s;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
            match_s = (shadow_s == EXPECT);
            ferr_s  = first_mismatch(shadow_s, EXPECT);
`endif
          end else begin
            idx_s = idx_r + 3'd1;
            cnt_s = RELOAD;
            abc_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        idx_s = 3'd0;
        cnt_s = 4'd0;
      end
    endcase
  end

  // Datapath and output registers; a reset discards any partial scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= 3'd0;
      cnt_r    <= 4'd0;
      shadow_r <= 8'h00;
      tbl_r    <= 8'h00;
      abc_r    <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
      match_r  <= 1'b0;
      ferr_r   <= 3'd0;
`endif
    end else begin
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      shadow_r <= shadow_s;
      tbl_r    <= tbl_s;
      abc_r    <= abc_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
      match_r  <= match_s;
      ferr_r   <= ferr_s;
`endif
    end
  end

  assign A    = abc_r[0];
  assign B    = abc_r[1];
  assign C    = abc_r[2];
  assign busy = busy_r;
  assign done = done_r;
  assign tbl  = tbl_r;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  assign match     = match_r;
  assign first_err = ferr_r;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) share
// start/rst_n and are each wired to a behavioural function model selected by
// 'mode'. Expected timing and tables are computed from the scan rules with
// plain arithmetic.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

  localparam logic [7:0] EXP = 8'h96;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic a1, b1, c1, fout1, busy1, done1;
  logic a3, b3, c3, fout3, busy3, done3;
  logic [7:0] tbl1, tbl3;
  logic match1, match3;
  logic [2:0] ferr1, ferr3;

  int mode = 0;
  logic [7:0] tt = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] old1, old3;
  logic       om1, om3;
  logic [2:0] of1, of3;

  typedef struct {
    int         mode;
    logic [7:0] tt;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Function model: 0 = (A&B)|C, 1 = A^B^C, 2 = constant 0, else lookup in tt.
  function automatic logic ref_bit(input int m, input logic [7:0] t, input int idx);
    int a, b, c;
    a = idx % 2;
    b = (idx / 2) % 2;
    c = idx / 4;
    case (m)
      0:       return ((a * b + c) > 0);
      1:       return (((a + b + c) % 2) == 1);
      2:       return 1'b0;
      default: return t[idx];
    endcase
  endfunction

  function automatic logic [7:0] ref_table(input int m, input logic [7:0] t);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ref_bit(m, t, i);
    return r;
  endfunction

  function automatic logic [2:0] ref_ferr(input logic [7:0] t);
    logic [7:0] d;
    int r;
    d = t ^ EXP;
    r = 0;
    for (int i = 7; i >= 0; i--) if (d[i]) r = i;
    return 3'(r);
  endfunction

  always_comb fout1 = ref_bit(mode, tt, int'({c1, b1, a1}));
  always_comb fout3 = ref_bit(mode, tt, int'({c3, b3, a3}));

  truth_table_scanner #(.SETTLE(1), .EXPECT(EXP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a1), .B(b1), .C(c1), .fout(fout1),
    .busy(busy1), .done(done1), .tbl(tbl1)
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    , .match(match1), .first_err(ferr1)
`endif
  );

  truth_table_scanner #(.SETTLE(3), .EXPECT(EXP)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(a3), .B(b3), .C(c3), .fout(fout3),
    .busy(busy3), .done(done3), .tbl(tbl3)
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    , .match(match3), .first_err(ferr3)
`endif
  );

`ifndef TRUTH_TABLE_SCANNER_COMPARE_EN
  assign match1 = 1'b0;
  assign match3 = 1'b0;
  assign ferr1  = 3'd0;
  assign ferr3  = 3'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare one instance at cycle c after a start accepted at edge 0.
  task automatic check_unit(input string tag, input int s, input int c,
                            input logic busy_a, input logic done_a,
                            input logic [2:0] abc_a, input logic [7:0] tbl_a,
                            input logic m_a, input logic [2:0] f_a,
                            input logic [7:0] old_t, input logic [7:0] new_t,
                            input logic old_m, input logic [2:0] old_f);
    logic eb, ed, em;
    logic [2:0] eabc, ef;
    logic [7:0] et;
    if (c <= 8 * s) begin
      eb = 1'b1; ed = 1'b0; eabc = 3'((c - 1) / s);
      et = old_t; em = old_m; ef = old_f;
    end else begin
      eb = 1'b0; ed = (c == 8 * s + 1); eabc = 3'd0;
      et = new_t; em = (new_t == EXP); ef = ref_ferr(new_t);
    end
    chk($sformatf("%s busy c%0d", tag, c), 32'(busy_a), 32'(eb));
    chk($sformatf("%s done c%0d", tag, c), 32'(done_a), 32'(ed));
    chk($sformatf("%s abc c%0d", tag, c), 32'(abc_a), 32'(eabc));
    chk($sformatf("%s table c%0d", tag, c), 32'(tbl_a), 32'(et));
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    chk($sformatf("%s match c%0d", tag, c), 32'(m_a), 32'(em));
    chk($sformatf("%s first_err c%0d", tag, c), 32'(f_a), 32'(ef));
`endif
  endtask

  // One scan on both instances; start pulses in cycles flagged by 'pulses'.
  task automatic run_scan(input int m, input logic [7:0] t, input logic [7:0] exp_t,
                          input logic [31:0] pulses);
    mode = m;
    tt   = t;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      check_unit("s1", 1, c, busy1, done1, {c1, b1, a1}, tbl1, match1, ferr1,
                 old1, exp_t, om1, of1);
      check_unit("s3", 3, c, busy3, done3, {c3, b3, a3}, tbl3, match3, ferr3,
                 old3, exp_t, om3, of3);
      start = pulses[c];
    end
    start = 1'b0;
    old1 = exp_t; om1 = (exp_t == EXP); of1 = ref_ferr(exp_t);
    old3 = exp_t; om3 = (exp_t == EXP); of3 = ref_ferr(exp_t);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy1"}, 32'(busy1), 32'd0);
    chk({tag, " done1"}, 32'(done1), 32'd0);
    chk({tag, " abc1"}, 32'({c1, b1, a1}), 32'd0);
    chk({tag, " table1"}, 32'(tbl1), 32'd0);
    chk({tag, " busy3"}, 32'(busy3), 32'd0);
    chk({tag, " done3"}, 32'(done3), 32'd0);
    chk({tag, " abc3"}, 32'({c3, b3, a3}), 32'd0);
    chk({tag, " table3"}, 32'(tbl3), 32'd0);
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    chk({tag, " match1"}, 32'(match1), 32'd0);
    chk({tag, " first_err1"}, 32'(ferr1), 32'd0);
    chk({tag, " match3"}, 32'(match3), 32'd0);
    chk({tag, " first_err3"}, 32'(ferr3), 32'd0);
`endif
  endtask

  task automatic clear_model();
    old1 = 8'h00; om1 = 1'b0; of1 = 3'd0;
    old3 = 8'h00; om3 = 1'b0; of3 = 3'd0;
  endtask

  initial begin
    logic [7:0] r;
    int p, s;
    logic eb, ed;

    // Vector table: fixed functions with hand-derived tables, then random ones.
    vecs[0] = '{mode: 0, tt: 8'h00, exp: 8'hF8};
    vecs[1] = '{mode: 2, tt: 8'h00, exp: 8'h00};
    vecs[2] = '{mode: 1, tt: 8'h00, exp: 8'h96};
    for (int i = 3; i < 8; i++) begin
      r = 8'($urandom);
      vecs[i] = '{mode: 3, tt: r, exp: ref_table(3, r)};
    end

    // Reset state.
    clear_model();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven scans; vecs[1] after vecs[0] shows F8 held through busy.
    for (int i = 0; i < 8; i++) run_scan(vecs[i].mode, vecs[i].tt, vecs[i].exp, 32'd0);

    // Start pulses during SCAN are ignored.
    run_scan(1, 8'h00, 8'h96, 32'h0000_0054);

    // Reset in cycle 5 of a scan: outputs clear at once, no done follows.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midscan");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("inreset done1 %0d", c), 32'(done1), 32'd0);
      chk($sformatf("inreset done3 %0d", c), 32'(done3), 32'd0);
    end
    rst_n = 1'b1;
    clear_model();
    run_scan(0, 8'h00, 8'hF8, 32'd0);

    // start held high: scans repeat with exactly one DONE cycle between them.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? 1 : 3;
        p = (c - 1) % (8 * s + 1);
        eb = (p < 8 * s);
        ed = (p == 8 * s);
        chk($sformatf("held s%0d busy c%0d", s, c), 32'((k == 0) ? busy1 : busy3), 32'(eb));
        chk($sformatf("held s%0d done c%0d", s, c), 32'((k == 0) ? done1 : done3), 32'(ed));
        chk($sformatf("held s%0d abc c%0d", s, c),
            32'((k == 0) ? {c1, b1, a1} : {c3, b3, a3}), eb ? 32'(p / s) : 32'd0);
        if (ed) chk($sformatf("held s%0d table c%0d", s, c),
                    32'((k == 0) ? tbl1 : tbl3), 32'h96);
      end
    end
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("final reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
